// File: rtl/pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_ctrl_if
// Control bus from the execute stage to the PC controller.
//   jump_en2ctrl   : execute stage requests a redirect this cycle
//   jump_addr2ctrl : redirect target, meaningful while jump_en2ctrl=1
//   hold2ctrl      : execute stage requests a pipeline freeze this cycle
// Modports: master = execute stage (drives), slave = pc_ctrl (consumes).
// -----------------------------------------------------------------------------
interface pc_ctrl_if;
  logic        jump_en2ctrl;
  logic [31:0] jump_addr2ctrl;
  logic        hold2ctrl;

  modport master (
    output jump_en2ctrl,
    output jump_addr2ctrl,
    output hold2ctrl
  );

  modport slave (
    input jump_en2ctrl,
    input jump_addr2ctrl,
    input hold2ctrl
  );
endinterface

// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
// Owns the program counter and produces the flush/hold controls for the PC,
// IF/ID and ID/EX pipeline registers. A taken redirect that arrives while
// instruction fetch is stalled is parked in a pending-target register and
// applied once fetch is ready again. Redirect and stall counters are kept for
// bring-up.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   ex_if           : execute-stage control bus (slave side)
//   fetch_rdy       : instruction memory accepts pc_o this cycle
//   pc_o            : current fetch address (registered)
//   flush_o         : bubble IF/ID and ID/EX (combinational)
//   hold_pc_o, hold_if_id_o, hold_id_ex_o : freeze controls (combinational)
//   pend_o          : a redirect target is buffered (registered)
//   misalign_o      : one-cycle pulse, accepted target had bits[1:0]!=0
//   redirect_cnt_o  : saturating count of accepted redirects
//   stall_cnt_o     : saturating count of cycles with hold_pc_o=1
// -----------------------------------------------------------------------------
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_ctrl_if.slave         ex_if,
  input  logic             fetch_rdy,
  output logic [31:0]      pc_o,
  output logic             flush_o,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             pend_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t             r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_pend_tgt;
  logic               r_pend;
  logic               r_misalign;
  logic [CNT_W-1:0]   r_redirect_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic [31:0]        w_tgt;
  logic               w_jump;
  logic               w_hold;
  logic               w_hold_pc;
  logic               w_hold_if_id;
  logic               w_hold_id_ex;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Gating with rst_n keeps every combinational control at 0 during reset.
  assign w_jump = ex_if.jump_en2ctrl & rst_n;
  assign w_hold = ex_if.hold2ctrl & rst_n;
  assign w_tgt  = {ex_if.jump_addr2ctrl[31:2], 2'b00};

  // Hold decode; priority is jump > hold > fetch_rdy.
  always_comb begin
    w_hold_pc    = 1'b0;
    w_hold_if_id = 1'b0;
    w_hold_id_ex = 1'b0;
    if (!rst_n) begin
      w_hold_pc    = 1'b0;
    end else if (w_jump) begin
      // Redirect flushes IF/ID and ID/EX; only the PC waits on fetch.
      w_hold_pc    = ~fetch_rdy;
    end else if (w_hold) begin
      w_hold_pc    = 1'b1;
      w_hold_if_id = 1'b1;
      w_hold_id_ex = 1'b1;
    end else if (!fetch_rdy) begin
      // Fetch stall: front end waits, ID/EX keeps draining.
      w_hold_pc    = 1'b1;
      w_hold_if_id = 1'b1;
    end else begin
      w_hold_pc    = 1'b0;
    end
  end

  // PC / pending-target FSM with its registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_PC;
      r_pend_tgt     <= 32'h0000_0000;
      r_pend         <= 1'b0;
      r_misalign     <= 1'b0;
      r_redirect_cnt <= {CNT_W{1'b0}};
      r_stall_cnt    <= {CNT_W{1'b0}};
    end else begin
      if (w_hold_pc) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
      if (w_jump) begin
        r_redirect_cnt <= sat_inc(r_redirect_cnt);
        r_misalign     <= (ex_if.jump_addr2ctrl[1:0] != 2'b00);
        if (fetch_rdy) begin
          r_pc    <= w_tgt;
          r_pend  <= 1'b0;
          r_state <= ST_RUN;
        end else begin
          // A newer redirect in PEND simply overwrites the parked target.
          r_pend_tgt <= w_tgt;
          r_pend     <= 1'b1;
          r_state    <= ST_PEND;
        end
      end else begin
        r_misalign <= 1'b0;
        if (!w_hold && fetch_rdy) begin
          case (r_state)
            ST_PEND: begin
              r_pc    <= r_pend_tgt;
              r_pend  <= 1'b0;
              r_state <= ST_RUN;
            end
            ST_RUN: begin
              r_pc <= r_pc + 32'd4;
            end
            default: begin
              r_state <= ST_RUN;
            end
          endcase
        end
      end
    end
  end

  assign pc_o           = r_pc;
  assign pend_o         = r_pend;
  assign misalign_o     = r_misalign;
  assign redirect_cnt_o = r_redirect_cnt;
  assign stall_cnt_o    = r_stall_cnt;
  assign flush_o        = w_jump;
  assign hold_pc_o      = w_hold_pc;
  assign hold_if_id_o   = w_hold_if_id;
  assign hold_id_ex_o   = w_hold_id_ex;

endmodule

// File: tb/tb_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_ctrl
// Directed-vector bench for pc_ctrl. A second instance with 2-bit counters
// shares the same stimulus so counter saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_pc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_rdy;

  logic [31:0] pc_o;
  logic        flush_o, hold_pc_o, hold_if_id_o, hold_id_ex_o, pend_o, misalign_o;
  logic [15:0] redirect_cnt_o, stall_cnt_o;

  logic [31:0] s_pc_o;
  logic        s_flush_o, s_hold_pc_o, s_hold_if_id_o, s_hold_id_ex_o, s_pend_o, s_misalign_o;
  logic [1:0]  s_redirect_cnt_o, s_stall_cnt_o;

  int n_checks;
  int n_errors;

  pc_ctrl_if ex_if ();

  pc_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_if(ex_if), .fetch_rdy(fetch_rdy),
    .pc_o(pc_o), .flush_o(flush_o), .hold_pc_o(hold_pc_o),
    .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
    .pend_o(pend_o), .misalign_o(misalign_o),
    .redirect_cnt_o(redirect_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  pc_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ex_if(ex_if), .fetch_rdy(fetch_rdy),
    .pc_o(s_pc_o), .flush_o(s_flush_o), .hold_pc_o(s_hold_pc_o),
    .hold_if_id_o(s_hold_if_id_o), .hold_id_ex_o(s_hold_id_ex_o),
    .pend_o(s_pend_o), .misalign_o(s_misalign_o),
    .redirect_cnt_o(s_redirect_cnt_o), .stall_cnt_o(s_stall_cnt_o)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are settled and inputs may change.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic jmp, input logic [31:0] addr, input logic hld, input logic rdy);
    ex_if.jump_en2ctrl   = jmp;
    ex_if.jump_addr2ctrl = addr;
    ex_if.hold2ctrl      = hld;
    fetch_rdy            = rdy;
    #1;
  endtask

  // Directed scenario sequence.
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    // Requests asserted during reset must not leak to the combinational outputs.
    drive(1'b1, 32'h0000_0040, 1'b1, 1'b0);
    #2;
    check_eq("rst_pc",       pc_o, 32'h0);
    check_eq("rst_pend",     {31'b0, pend_o}, 32'h0);
    check_eq("rst_misalign", {31'b0, misalign_o}, 32'h0);
    check_eq("rst_flush",    {31'b0, flush_o}, 32'h0);
    check_eq("rst_hold_pc",  {31'b0, hold_pc_o}, 32'h0);
    check_eq("rst_hold_ifid",{31'b0, hold_if_id_o}, 32'h0);
    check_eq("rst_redir",    {16'b0, redirect_cnt_o}, 32'h0);
    check_eq("rst_stall",    {16'b0, stall_cnt_o}, 32'h0);

    // 1: sequential fetch from reset.
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("seq_pc",    pc_o, 32'(i * 4));
      check_eq("seq_flush", {31'b0, flush_o}, 32'h0);
      if (i < 4) tick();
    end
    check_eq("seq_redir", {16'b0, redirect_cnt_o}, 32'h0);
    check_eq("seq_stall", {16'b0, stall_cnt_o}, 32'h0);

    // 2: aligned redirect at pc=0x10.
    drive(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    check_eq("j1_flush",   {31'b0, flush_o}, 32'h1);
    check_eq("j1_hold_pc", {31'b0, hold_pc_o}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("j1_pc",       pc_o, 32'h0000_0100);
    check_eq("j1_redir",    {16'b0, redirect_cnt_o}, 32'h1);
    check_eq("j1_misalign", {31'b0, misalign_o}, 32'h0);

    // 3: misaligned jump beats a simultaneous hold.
    drive(1'b1, 32'h0000_0102, 1'b1, 1'b1);
    check_eq("j2_flush",    {31'b0, flush_o}, 32'h1);
    check_eq("j2_hold_pc",  {31'b0, hold_pc_o}, 32'h0);
    check_eq("j2_hold_idex",{31'b0, hold_id_ex_o}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("j2_pc",       pc_o, 32'h0000_0100);
    check_eq("j2_misalign", {31'b0, misalign_o}, 32'h1);
    check_eq("j2_redir",    {16'b0, redirect_cnt_o}, 32'h2);
    check_eq("j2_stall",    {16'b0, stall_cnt_o}, 32'h0);
    tick();
    check_eq("j2_mis_drop", {31'b0, misalign_o}, 32'h0);
    check_eq("j2_pc_next",  pc_o, 32'h0000_0104);

    // 4: redirect during a three-cycle fetch stall.
    drive(1'b1, 32'h0000_0200, 1'b0, 1'b0);
    check_eq("p1_hold_pc", {31'b0, hold_pc_o}, 32'h1);
    check_eq("p1_flush",   {31'b0, flush_o}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("p1_pend",  {31'b0, pend_o}, 32'h1);
    check_eq("p1_pc",    pc_o, 32'h0000_0104);
    check_eq("p1_redir", {16'b0, redirect_cnt_o}, 32'h3);
    tick();
    check_eq("p1_pc2",        pc_o, 32'h0000_0104);
    check_eq("p1_hold_pc2",   {31'b0, hold_pc_o}, 32'h1);
    check_eq("p1_hold_ifid",  {31'b0, hold_if_id_o}, 32'h1);
    check_eq("p1_hold_idex",  {31'b0, hold_id_ex_o}, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("p1_stall",    {16'b0, stall_cnt_o}, 32'h3);
    check_eq("p1_hold_rdy", {31'b0, hold_pc_o}, 32'h0);
    check_eq("p1_pc3",      pc_o, 32'h0000_0104);
    tick();
    check_eq("p1_apply_pc", pc_o, 32'h0000_0200);
    check_eq("p1_pend_clr", {31'b0, pend_o}, 32'h0);

    // Pure hold in RUN freezes everything without a flush.
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("h_flush",    {31'b0, flush_o}, 32'h0);
    check_eq("h_hold_pc",  {31'b0, hold_pc_o}, 32'h1);
    check_eq("h_hold_ifid",{31'b0, hold_if_id_o}, 32'h1);
    check_eq("h_hold_idex",{31'b0, hold_id_ex_o}, 32'h1);
    tick();
    check_eq("h_pc",    pc_o, 32'h0000_0200);
    check_eq("h_stall", {16'b0, stall_cnt_o}, 32'h4);

    // 5: park 0x280, hold in PEND, then overwrite with 0x300.
    drive(1'b1, 32'h0000_0280, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("p2_pend",      {31'b0, pend_o}, 32'h1);
    check_eq("p2_redir",     {16'b0, redirect_cnt_o}, 32'h4);
    check_eq("p2_hold_idex", {31'b0, hold_id_ex_o}, 32'h1);
    tick();
    drive(1'b1, 32'h0000_0300, 1'b0, 1'b0);
    check_eq("p2_pend_kept", {31'b0, pend_o}, 32'h1);
    check_eq("p2_pc_held",   pc_o, 32'h0000_0200);
    check_eq("p2_flush2",    {31'b0, flush_o}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check_eq("p2_apply_pc", pc_o, 32'h0000_0300);
    check_eq("p2_pend_clr", {31'b0, pend_o}, 32'h0);
    check_eq("p2_redir2",   {16'b0, redirect_cnt_o}, 32'h5);

    // 6: park 0x400, then assert reset mid-cycle.
    drive(1'b1, 32'h0000_0400, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_eq("p3_pend",   {31'b0, pend_o}, 32'h1);
    check_eq("p3_stall",  {16'b0, stall_cnt_o}, 32'h8);
    check_eq("sat_redir", {30'b0, s_redirect_cnt_o}, 32'h3);
    check_eq("sat_stall", {30'b0, s_stall_cnt_o}, 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("ar_pc",    pc_o, 32'h0);
    check_eq("ar_pend",  {31'b0, pend_o}, 32'h0);
    check_eq("ar_redir", {16'b0, redirect_cnt_o}, 32'h0);
    check_eq("ar_stall", {16'b0, stall_cnt_o}, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("ar_no_pend_pc", pc_o, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
